// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder for a bank of 32-bit control/status registers.
// Index 0 is a constant ID, index 1 samples status_i, the rest are read/write.
module axi_lite_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    N_REGS     = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11C_0001,
    parameter bit                    STRB_EN    = 1'b0
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [ADDR_WIDTH-1:0]            awaddr,
    input  logic                             awvalid,
    output logic                             awready,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/8-1:0]          wstrb,
    input  logic                             wvalid,
    output logic                             wready,
    output logic [1:0]                       bresp,
    output logic                             bvalid,
    input  logic                             bready,
    input  logic [ADDR_WIDTH-1:0]            araddr,
    input  logic                             arvalid,
    output logic                             arready,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [1:0]                       rresp,
    output logic                             rvalid,
    input  logic                             rready,
    input  logic [DATA_WIDTH-1:0]            status_i,
    output logic [(N_REGS-2)*DATA_WIDTH-1:0] ctrl_o,
    output logic [N_REGS-2-1:0]              wr_pulse_o
);

    localparam int              IDX_W       = $clog2(N_REGS);
    localparam int              N_RW        = N_REGS - 2;
    localparam int              STRB_W      = DATA_WIDTH / 8;
    localparam logic [IDX_W:0]  IDX_LIMIT   = (IDX_W + 1)'(N_REGS);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // Byte-lane merge; with strobes disabled every lane takes the new data.
    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = (strb[b] || !STRB_EN) ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic idx_is_rw(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} >= (IDX_W + 1)'(2)) && ({1'b0, idx} < IDX_LIMIT);
    endfunction

    logic [DATA_WIDTH-1:0] regs_r [N_RW];
    logic [N_RW-1:0]       wr_pulse_r;

    w_state_t              w_state_r, w_state_nxt_s;
    logic                  aw_got_r, w_got_r, aw_got_nxt_s, w_got_nxt_s;
    logic                  awready_r, wready_r, bvalid_r;
    logic                  awready_nxt_s, wready_nxt_s, bvalid_nxt_s;
    logic [1:0]            bresp_r;
    logic [IDX_W-1:0]      aw_idx_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_W-1:0]     wstrb_r;
    logic                  aw_hs_s, w_hs_s, aw_have_s, w_have_s, commit_s, wr_ok_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [STRB_W-1:0]     wr_strb_s;

    r_state_t              r_state_r, r_state_nxt_s;
    logic                  arready_r, rvalid_r, arready_nxt_s, rvalid_nxt_s;
    logic [DATA_WIDTH-1:0] rdata_r, rd_data_s, rw_data_s;
    logic [1:0]            rresp_r, rd_resp_s;
    logic                  ar_hs_s;
    logic [IDX_W-1:0]      rd_idx_s;

    logic                  unused_s;

    // A commit may combine a latched half with a handshake in this cycle.
    assign aw_hs_s   = awvalid && awready_r;
    assign w_hs_s    = wvalid && wready_r;
    assign aw_have_s = aw_got_r || aw_hs_s;
    assign w_have_s  = w_got_r || w_hs_s;
    assign wr_idx_s  = aw_hs_s ? awaddr[2 +: IDX_W] : aw_idx_r;
    assign wr_data_s = w_hs_s ? wdata : wdata_r;
    assign wr_strb_s = w_hs_s ? wstrb : wstrb_r;
    assign wr_ok_s   = commit_s && idx_is_rw(wr_idx_s);

    // Write FSM next-state, handshake flags and ready/valid next values.
    always_comb begin
        w_state_nxt_s = w_state_r;
        aw_got_nxt_s  = aw_got_r;
        w_got_nxt_s   = w_got_r;
        bvalid_nxt_s  = bvalid_r;
        commit_s      = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_have_s && w_have_s) begin
                    commit_s      = 1'b1;
                    aw_got_nxt_s  = 1'b0;
                    w_got_nxt_s   = 1'b0;
                    bvalid_nxt_s  = 1'b1;
                    w_state_nxt_s = W_RESP;
                end else begin
                    aw_got_nxt_s  = aw_have_s;
                    w_got_nxt_s   = w_have_s;
                    bvalid_nxt_s  = 1'b0;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_nxt_s  = 1'b0;
                    w_state_nxt_s = W_IDLE;
                end else begin
                    bvalid_nxt_s  = 1'b1;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
                aw_got_nxt_s  = 1'b0;
                w_got_nxt_s   = 1'b0;
                bvalid_nxt_s  = 1'b0;
            end
        endcase
        awready_nxt_s = (w_state_nxt_s == W_IDLE) && !aw_got_nxt_s;
        wready_nxt_s  = (w_state_nxt_s == W_IDLE) && !w_got_nxt_s;
    end

    // Write FSM state and registered handshake outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_r <= W_IDLE;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            w_state_r <= w_state_nxt_s;
            aw_got_r  <= aw_got_nxt_s;
            w_got_r   <= w_got_nxt_s;
            awready_r <= awready_nxt_s;
            wready_r  <= wready_nxt_s;
            bvalid_r  <= bvalid_nxt_s;
        end
    end

    // Latched AW/W payloads and the write response code.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_idx_r <= '0;
            wdata_r  <= '0;
            wstrb_r  <= '0;
            bresp_r  <= RESP_OKAY;
        end else begin
            if (aw_hs_s) begin
                aw_idx_r <= awaddr[2 +: IDX_W];
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            if (commit_s) begin
                bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register bank update and per-register write strobes.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int k = 0; k < N_RW; k++) begin
                regs_r[k] <= '0;
            end
            wr_pulse_r <= '0;
        end else begin
            for (int k = 0; k < N_RW; k++) begin
                if (wr_ok_s && (wr_idx_s == IDX_W'(k + 2))) begin
                    regs_r[k]     <= strb_merge(regs_r[k], wr_data_s, wr_strb_s);
                    wr_pulse_r[k] <= 1'b1;
                end else begin
                    wr_pulse_r[k] <= 1'b0;
                end
            end
        end
    end

    assign ar_hs_s  = arvalid && arready_r;
    assign rd_idx_s = araddr[2 +: IDX_W];

    // Read data select; registers are sampled before any same-edge write lands.
    always_comb begin
        rw_data_s = '0;
        for (int k = 0; k < N_RW; k++) begin
            rw_data_s = rw_data_s | (regs_r[k] & {DATA_WIDTH{rd_idx_s == IDX_W'(k + 2)}});
        end
        rd_data_s = '0;
        rd_resp_s = RESP_OKAY;
        if (rd_idx_s == IDX_W'(0)) begin
            rd_data_s = ID_VALUE;
        end else if (rd_idx_s == IDX_W'(1)) begin
            rd_data_s = status_i;
        end else if (idx_is_rw(rd_idx_s)) begin
            rd_data_s = rw_data_s;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
        end
    end

    // Read FSM next-state and ready/valid next values.
    always_comb begin
        r_state_nxt_s = r_state_r;
        rvalid_nxt_s  = rvalid_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_nxt_s = R_DATA;
                    rvalid_nxt_s  = 1'b1;
                end else begin
                    rvalid_nxt_s  = 1'b0;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_nxt_s = R_IDLE;
                    rvalid_nxt_s  = 1'b0;
                end else begin
                    rvalid_nxt_s  = 1'b1;
                end
            end
            default: begin
                r_state_nxt_s = R_IDLE;
                rvalid_nxt_s  = 1'b0;
            end
        endcase
        arready_nxt_s = (r_state_nxt_s == R_IDLE);
    end

    // Read FSM state, handshake outputs and response snapshot.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_nxt_s;
            arready_r <= arready_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            if (ar_hs_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

    for (genvar g = 0; g < N_RW; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
    end

    assign awready    = awready_r;
    assign wready     = wready_r;
    assign bvalid     = bvalid_r;
    assign bresp      = bresp_r;
    assign arready    = arready_r;
    assign rvalid     = rvalid_r;
    assign rdata      = rdata_r;
    assign rresp      = rresp_r;
    assign wr_pulse_o = wr_pulse_r;

    // Address bits outside the index field are decoded upstream.
    assign unused_s = ^{awaddr, araddr};

endmodule
